// File: rtl/comb_sweep_pkg.sv
// Shared types and constants for the combLogic sweep sequencer.
package comb_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    OBSERVE,
    REPORT,
    DONE
  } state_t;

  localparam int unsigned N_IN_DEF  = 8;
  localparam int unsigned N_OBS_DEF = 14;

  // Value deposited onto the loop-breaking net on each APPLY cycle.
  localparam logic DEP_VAL = 1'b1;

endpackage

// File: rtl/obs_change_det.sv
// Observation-window comparator: captures a reference on 'first', then flags any later difference.
module obs_change_det
  import comb_sweep_pkg::*;
#(
  parameter int unsigned N_OBS = N_OBS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             first,
  input  logic             en,
  input  logic [N_OBS-1:0] obs_in,
  output logic             changed
);

  logic [N_OBS-1:0] ref_obs;
  logic             sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_obs <= '0;
      sticky  <= 1'b0;
    end else if (first) begin
      ref_obs <= obs_in;
      sticky  <= 1'b0;
    end else if (en && (obs_in != ref_obs)) begin
      sticky <= 1'b1;
    end
  end

  // Includes the current cycle so the last window cycle is counted too.
  assign changed = sticky | (en & (obs_in != ref_obs));

endmodule

// File: rtl/comb_sweep_ctrl.sv
// Sweeps every input vector through combLogic, observes internal nets, reports per-vector results.
module comb_sweep_ctrl
  import comb_sweep_pkg::*;
#(
  parameter int unsigned N_IN       = N_IN_DEF,
  parameter int unsigned N_OBS      = N_OBS_DEF,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned OBS_CYC    = 3,
  parameter int unsigned DEP_EN     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec_out,
  output logic             dep_en,
  input  logic [N_OBS-1:0] obs_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N_IN-1:0]  res_vec,
  output logic [N_OBS-1:0] res_obs,
  output logic             res_osc,
  output logic [N_IN:0]    osc_cnt,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TMAX = (SETTLE_CYC > OBS_CYC) ? SETTLE_CYC : OBS_CYC;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] OBS_LAST    = TW'(OBS_CYC - 1);

  state_t           state_q, state_d;
  logic [N_IN-1:0]  cnt_q;
  logic [TW-1:0]    tmr_q;
  logic [N_IN-1:0]  res_vec_q;
  logic [N_OBS-1:0] res_obs_q;
  logic             res_osc_q;
  logic [N_IN:0]    osc_cnt_q;

  logic obs_first, obs_en, obs_last, changed, handshake;

  assign obs_first = (state_q == OBSERVE) && (tmr_q == '0);
  assign obs_en    = (state_q == OBSERVE) && (tmr_q != '0);
  assign obs_last  = (state_q == OBSERVE) && (tmr_q == OBS_LAST);
  assign handshake = (state_q == REPORT) && res_ready && !abort;

  obs_change_det #(
    .N_OBS (N_OBS)
  ) u_det (
    .clk     (clk),
    .rst     (rst),
    .first   (obs_first),
    .en      (obs_en),
    .obs_in  (obs_in),
    .changed (changed)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   state_d = SETTLE;
      SETTLE:  if (tmr_q == SETTLE_LAST) state_d = OBSERVE;
      OBSERVE: if (tmr_q == OBS_LAST) state_d = REPORT;
      REPORT:  if (res_ready) state_d = (cnt_q == '1) ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      res_vec_q <= '0;
      res_obs_q <= '0;
      res_osc_q <= 1'b0;
      osc_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // Timer restarts on every state change, so it counts cycles spent in the current state.
      tmr_q   <= (state_d != state_q) ? '0 : tmr_q + TW'(1);
      if ((state_q == IDLE) && start && !abort) begin
        cnt_q     <= '0;
        osc_cnt_q <= '0;
      end
      if (obs_last) begin
        res_vec_q <= cnt_q;
        res_obs_q <= obs_in;
        res_osc_q <= changed;
      end
      if (handshake) begin
        osc_cnt_q <= osc_cnt_q + (N_IN + 1)'(res_osc_q);
        if (cnt_q != '1) cnt_q <= cnt_q + N_IN'(1);
      end
    end
  end

  assign vec_out   = (state_q inside {APPLY, SETTLE, OBSERVE, REPORT}) ? cnt_q : '0;
  assign dep_en    = (state_q == APPLY) && (DEP_EN != 0) && DEP_VAL;
  assign res_valid = (state_q == REPORT);
  assign res_vec   = res_vec_q;
  assign res_obs   = res_obs_q;
  assign res_osc   = res_osc_q;
  assign osc_cnt   = osc_cnt_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Scoreboard bench for comb_sweep_ctrl: directed sweeps, stall, abort and mid-sweep reset.
module tb_comb_sweep_ctrl;

  localparam logic [13:0] OBS_C = 14'h2A5C;

  typedef struct {
    logic [7:0]  vec;
    logic        osc;
    logic [13:0] obs;
    bit          chk_obs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, abort, res_ready;
  logic [7:0]  vec_out, res_vec;
  logic        dep_en, res_valid, res_osc, busy, done;
  logic [13:0] obs_in, res_obs;
  logic [8:0]  osc_cnt;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   dep_cnt = 0;
  int   stall_cnt = 0;
  bit   stall_en = 0;
  bit   post_stall = 0;
  bit   tog_en = 0;
  logic tog_bit = 1'b0;
  exp_t sb[$];

  comb_sweep_ctrl #(
    .N_IN       (8),
    .N_OBS      (14),
    .SETTLE_CYC (4),
    .OBS_CYC    (3),
    .DEP_EN     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .vec_out   (vec_out),
    .dep_en    (dep_en),
    .obs_in    (obs_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_vec   (res_vec),
    .res_obs   (res_obs),
    .res_osc   (res_osc),
    .osc_cnt   (osc_cnt),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs_in = OBS_C ^ {13'b0, tog_bit};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vec_out"}, vec_out, 0);
    chk({tag, "_dep_en"}, dep_en, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_vec"}, res_vec, 0);
    chk({tag, "_res_obs"}, res_obs, 0);
    chk({tag, "_res_osc"}, res_osc, 0);
    chk({tag, "_osc_cnt"}, osc_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic push_sweep(input bit tog);
    exp_t e;
    for (int v = 0; v < 256; v++) begin
      e.vec     = 8'(v);
      e.osc     = tog && (v == 5);
      e.obs     = OBS_C;
      e.chk_obs = !(tog && (v == 5));
      sb.push_back(e);
    end
  endtask

  task automatic do_start(output int t0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int t1);
    int n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    t1 = cyc;
  endtask

  // Toggles obs_in[0] every cycle while vector 5 is on the inputs.
  always @(posedge clk) begin
    #1;
    if (tog_en && vec_out == 8'h05) tog_bit = ~tog_bit;
    else tog_bit = 1'b0;
  end

  // Consumer: stalls vector 3 for 20 cycles when enabled.
  always @(posedge clk) begin
    #1;
    if (stall_en && res_valid && res_vec == 8'd3 && stall_cnt < 20) begin
      if (stall_cnt > 0) chk("stall_vec_out", vec_out, 3);
      res_ready = 1'b0;
      stall_cnt++;
    end else begin
      if (post_stall) begin
        chk("post_stall_vec_out", vec_out, 4);
        chk("post_stall_dep_en", dep_en, 1);
        post_stall = 0;
      end
      if (res_ready === 1'b0) post_stall = 1;
      res_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_vec", res_vec, 9'h100);
      end else begin
        e = sb.pop_front();
        chk("res_vec", res_vec, e.vec);
        chk("res_osc", res_osc, e.osc);
        if (e.chk_obs) chk("res_obs", res_obs, e.obs);
      end
    end
    if (done) done_cnt++;
    if (dep_en) dep_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n, d;
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Sweep A: constant nets, ready high.
    push_sweep(0);
    dep_cnt = 0;
    do_start(t0);
    wait_done("sweepA", t1);
    chk("sweepA_latency", t1 - t0, 2304);
    chk("sweepA_osc_cnt", osc_cnt, 0);
    chk("sweepA_dep_cnt", dep_cnt, 256);
    chk("sweepA_sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    chk("sweepA_done_pulse", done, 0);
    chk("sweepA_idle_busy", busy, 0);
    chk("sweepA_idle_vec", vec_out, 0);
    chk("sweepA_osc_hold", osc_cnt, 0);

    // Sweep B: vector 5 oscillates.
    tog_en = 1;
    push_sweep(1);
    do_start(t0);
    wait_done("sweepB", t1);
    chk("sweepB_osc_cnt", osc_cnt, 1);
    chk("sweepB_sb_empty", sb.size(), 0);

    // Sweep C: stall vector 3, abort during SETTLE of vector 10.
    stall_en = 1; stall_cnt = 0;
    push_sweep(1);
    do_start(t0);
    chk("sweepC_start_clears_osc", osc_cnt, 0);
    n = 0;
    while (!(vec_out == 8'd10 && busy && !dep_en) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sweepC_reach_v10", vec_out, 10);
    chk("sweepC_stall_len", stall_cnt, 20);
    chk("sweepC_osc_before_abort", osc_cnt, 1);
    d = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    sb.delete();
    chk("abort_busy", busy, 0);
    chk("abort_vec_out", vec_out, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_dep_en", dep_en, 0);
    chk("abort_osc_cnt", osc_cnt, 1);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_same_cycle_busy", busy, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d);
    chk("abort_osc_hold", osc_cnt, 1);
    stall_en = 0; tog_en = 0;

    // Sweep D: restarts from vector 0; a start while busy is ignored.
    push_sweep(0);
    do_start(t0);
    n = 0;
    while (vec_out != 8'd20 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_start_ignored", busy, 1);
    wait_done("sweepD", t1);
    chk("sweepD_osc_cnt", osc_cnt, 0);
    chk("sweepD_sb_empty", sb.size(), 0);

    // Sweep E: reset during OBSERVE of vector 7.
    push_sweep(0);
    do_start(t0);
    n = 0;
    while (!(vec_out == 8'd7 && dep_en) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sweepE_apply_v7", vec_out, 7);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    sb.delete();
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_idle_busy", busy, 0);
    chk("midrst_idle_valid", res_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
